conway_run_ctrl: RTL and testbench



---
 rtl/conway_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_conway_run_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_run_ctrl.sv
// Run-sequencing controller for the 8x8 Conway grid.
// It drives the grid clock-enable and load/run select, counts generations and detects halt conditions.
module conway_run_ctrl #(
  parameter int CELLS = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOAD,
  input  logic             START,
  input  logic             STOP,
  input  logic             STEP,
  input  logic [CNT_W-1:0] GEN_LIMIT,
  input  logic [CELLS-1:0] CURRENT_STATE,
  input  logic [CELLS-1:0] NEXT_STATE,
  output logic             CLK_EN,
  output logic             LOAD_RUN,
  output logic [CNT_W-1:0] GEN_COUNT,
  output logic             BUSY,
  output logic             HALTED,
  output logic [1:0]       HALT_CAUSE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_HALT
  } state_e;

  localparam logic [1:0] CAUSE_LIMIT   = 2'd0;
  localparam logic [1:0] CAUSE_EXTINCT = 2'd1;
  localparam logic [1:0] CAUSE_STILL   = 2'd2;
  localparam logic [1:0] CAUSE_OSC2    = 2'd3;

  state_e             state_q, state_d;
  logic               loaded_q, loaded_d;
  logic               prev_valid_q, prev_valid_d;
  logic [CELLS-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   gen_count_q, gen_count_d;
  logic               load_run_q, load_run_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic [1:0]         halt_cause_q, halt_cause_d;
  logic               clk_en_q;
  logic               en_dec;

  logic               run_adv;
  logic               load_adv;
  logic               halt_hit;
  logic [1:0]         hit_cause;
  logic [CNT_W:0]     gen_plus;

  // An advance happens on every rising edge where the committed enable is high.
  assign run_adv  = clk_en_q &  load_run_q;
  assign load_adv = clk_en_q & ~load_run_q;
  assign gen_plus = {1'b0, gen_count_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    halt_hit  = 1'b1;
    hit_cause = CAUSE_LIMIT;
    if (NEXT_STATE == '0) begin
      hit_cause = CAUSE_EXTINCT;
    end else if (NEXT_STATE == CURRENT_STATE) begin
      hit_cause = CAUSE_STILL;
    end else if (prev_valid_q && (NEXT_STATE == prev_q)) begin
      hit_cause = CAUSE_OSC2;
    end else if ((GEN_LIMIT != '0) && (gen_plus == {1'b0, GEN_LIMIT})) begin
      hit_cause = CAUSE_LIMIT;
    end else begin
      halt_hit = 1'b0;
    end
  end

  // Next-state logic: LOAD beats everything, then a halt detected on a run advance, then per-state commands.
  always_comb begin
    state_d      = state_q;
    halt_cause_d = halt_cause_q;
    if (LOAD) begin
      state_d = ST_LOAD;
    end else if (run_adv && halt_hit) begin
      state_d      = ST_HALT;
      halt_cause_d = hit_cause;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!STOP && loaded_q) begin
            if (STEP)       state_d = ST_STEP;
            else if (START) state_d = ST_RUN;
          end
        end
        ST_LOAD: if (clk_en_q) state_d = ST_IDLE;
        ST_RUN:  if (STOP)     state_d = ST_IDLE;
        ST_STEP: if (clk_en_q) state_d = ST_IDLE;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    gen_count_d  = gen_count_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    loaded_d     = loaded_q;
    if (load_adv) begin
      gen_count_d  = '0;
      prev_valid_d = 1'b0;
      loaded_d     = 1'b1;
    end else if (run_adv) begin
      if (gen_count_q != '1) gen_count_d = gen_count_q + 1'b1;
      prev_d       = CURRENT_STATE;
      prev_valid_d = 1'b1;
    end
  end

  // Output decode; registered outputs follow the state being entered.
  always_comb begin
    load_run_d = 1'b1;
    busy_d     = 1'b0;
    halted_d   = 1'b0;
    en_dec     = 1'b0;
    case (state_d)
      ST_IDLE: load_run_d = loaded_d;
      ST_LOAD: load_run_d = 1'b0;
      ST_RUN,
      ST_STEP: busy_d     = 1'b1;
      ST_HALT: halted_d   = 1'b1;
      default: load_run_d = 1'b1;
    endcase
    case (state_q)
      ST_LOAD, ST_RUN, ST_STEP: en_dec = 1'b1;
      default:                  en_dec = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      loaded_q     <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
      gen_count_q  <= '0;
      load_run_q   <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      halt_cause_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      prev_valid_q <= prev_valid_d;
      prev_q       <= prev_d;
      gen_count_q  <= gen_count_d;
      load_run_q   <= load_run_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      halt_cause_q <= halt_cause_d;
    end
  end

  // The enable is captured on the falling edge so it is stable for the grid's AND-gated clock.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) clk_en_q <= 1'b0;
    else          clk_en_q <= en_dec;
  end

  assign CLK_EN     = clk_en_q;
  assign LOAD_RUN   = load_run_q;
  assign GEN_COUNT  = gen_count_q;
  assign BUSY       = busy_q;
  assign HALTED     = halted_q;
  assign HALT_CAUSE = halt_cause_q;

endmodule

// File: tb/tb_conway_run_ctrl.sv
// Self-checking bench for conway_run_ctrl with a behavioural 8x8 Life grid attached.
// Directed table cases, hand-written command sequences and random patterns against a generation-level model.
module tb_conway_run_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic        LOAD, START, STOP, STEP;
  logic [15:0] GEN_LIMIT;
  logic [63:0] CURRENT_STATE, NEXT_STATE;
  logic        CLK_EN, LOAD_RUN, BUSY, HALTED;
  logic [15:0] GEN_COUNT;
  logic [1:0]  HALT_CAUSE;

  logic [63:0] grid_q = '0;
  logic [63:0] init_state = '0;
  int          adv_count = 0;
  int          assertions = 0;
  int          failures = 0;

  typedef struct {
    logic [63:0] pat;
    logic [15:0] lim;
    logic [63:0] gen;
    logic [63:0] cause;
    logic [63:0] fin;
  } vec_t;

  conway_run_ctrl #(.CELLS(64), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD), .START(START), .STOP(STOP), .STEP(STEP),
    .GEN_LIMIT(GEN_LIMIT), .CURRENT_STATE(CURRENT_STATE), .NEXT_STATE(NEXT_STATE),
    .CLK_EN(CLK_EN), .LOAD_RUN(LOAD_RUN), .GEN_COUNT(GEN_COUNT), .BUSY(BUSY),
    .HALTED(HALTED), .HALT_CAUSE(HALT_CAUSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] lifeNext(input logic [63:0] s);
    logic [63:0] n;
    logic [5:0]  idx;
    int          cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
              idx = 6'(rr * 8 + cc);
              if (s[idx]) cnt++;
            end
          end
        end
        idx = 6'(r * 8 + c);
        n[idx] = s[idx] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  // The grid: loads the initial pattern or steps one generation on each enabled rising edge.
  always @(posedge CLK) begin
    if (CLK_EN) begin
      if (LOAD_RUN) begin
        grid_q    <= lifeNext(grid_q);
        adv_count <= adv_count + 1;
      end else begin
        grid_q <= init_state;
      end
    end
  end

  assign CURRENT_STATE = grid_q;
  assign NEXT_STATE    = lifeNext(grid_q);

  task automatic predict(input logic [63:0] pat, input int lim, output int gen, output int cause,
                         output logic [63:0] fin);
    logic [63:0] cur, prv, nxt;
    bit          pv, done;
    int          k;
    cur = pat; prv = '0; pv = 0; done = 0; k = 0; cause = 0;
    while (!done && k < 1000) begin
      k++;
      nxt = lifeNext(cur);
      if (nxt == '0) begin
        cause = 1; done = 1;
      end else if (nxt == cur) begin
        cause = 2; done = 1;
      end else if (pv && nxt == prv) begin
        cause = 3; done = 1;
      end else if (lim != 0 && k == lim) begin
        cause = 0; done = 1;
      end
      prv = cur; pv = 1; cur = nxt;
    end
    gen = k;
    fin = cur;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic s, input logic p, input logic t);
    LOAD = l; START = s; STOP = p; STEP = t;
    @(posedge CLK); #1;
    LOAD = 1'b0; START = 1'b0; STOP = 1'b0; STEP = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic loadPattern(input logic [63:0] pat, input logic [15:0] lim);
    init_state = pat;
    GEN_LIMIT  = lim;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("load_count", 64'(GEN_COUNT), 64'd0);
    checkOutput("load_grid", CURRENT_STATE, pat);
    checkOutput("load_idle", 64'({BUSY, HALTED, LOAD_RUN}), 64'b001);
  endtask

  task automatic runCase(input logic [63:0] pat, input logic [15:0] lim, input logic [63:0] egen,
                         input logic [63:0] ecause, input logic [63:0] efin);
    int base, waited;
    loadPattern(pat, lim);
    base = adv_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waited = 0;
    while (!HALTED && waited < 300) begin
      @(posedge CLK); #1;
      waited++;
    end
    checkOutput("halt_seen", 64'(HALTED), 64'd1);
    checkOutput("halt_gen", 64'(GEN_COUNT), egen);
    checkOutput("halt_cause", 64'(HALT_CAUSE), ecause);
    checkOutput("halt_advances", 64'(adv_count - base), egen);
    checkOutput("halt_grid", CURRENT_STATE, efin);
    checkOutput("clk_en_committed", 64'(CLK_EN), 64'd1);
    @(negedge CLK); #1;
    checkOutput("clk_en_dropped", 64'(CLK_EN), 64'd0);
    @(posedge CLK); #1;
    checkOutput("no_extra_advance", 64'(adv_count - base), egen);
  endtask

  initial begin
    vec_t        vecs[4];
    int          base, waited, pgen, pcause, plim;
    logic [63:0] pfin, rpat;

    vecs[0] = '{pat: 64'h0000_0000_0800_0000, lim: 16'd0, gen: 64'd1, cause: 64'd1, fin: 64'h0};
    vecs[1] = '{pat: 64'h0000_0018_1800_0000, lim: 16'd0, gen: 64'd1, cause: 64'd2,
                fin: 64'h0000_0018_1800_0000};
    vecs[2] = '{pat: 64'h0000_0000_1C00_0000, lim: 16'd0, gen: 64'd2, cause: 64'd3,
                fin: 64'h0000_0000_1C00_0000};
    vecs[3] = '{pat: 64'h0000_001C_1008_0000, lim: 16'd4, gen: 64'd4, cause: 64'd0,
                fin: 64'h0000_3820_1000_0000};

    RESET_N = 1'b0; LOAD = 1'b0; START = 1'b0; STOP = 1'b0; STEP = 1'b0; GEN_LIMIT = '0;
    waitCycles(3);
    checkOutput("reset_outputs", 64'({CLK_EN, LOAD_RUN, BUSY, HALTED, HALT_CAUSE}), 64'd0);
    checkOutput("reset_count", 64'(GEN_COUNT), 64'd0);
    #2 RESET_N = 1'b1;
    waitCycles(1);

    base = adv_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("start_before_load", 64'({BUSY, CLK_EN}), 64'd0);
    checkOutput("start_before_load_adv", 64'(adv_count - base), 64'd0);

    $display("[TB] directed table");
    for (int i = 0; i < 4; i++) begin
      runCase(vecs[i].pat, vecs[i].lim, vecs[i].gen, vecs[i].cause, vecs[i].fin);
    end

    // Halted on the limit: START must be ignored until a new LOAD.
    base = adv_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("halt_start_ignored", 64'({HALTED, BUSY}), 64'b10);
    checkOutput("halt_start_no_adv", 64'(adv_count - base), 64'd0);
    checkOutput("halt_start_count", 64'(GEN_COUNT), 64'd4);
    loadPattern(64'h0000_001C_1008_0000, 16'd4);
    checkOutput("load_clears_halt", 64'(HALTED), 64'd0);

    $display("[TB] step sequence");
    loadPattern(64'h0000_0000_1C00_0000, 16'd0);
    base = adv_count;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("step1_busy", 64'(BUSY), 64'd1);
    waitCycles(1);
    checkOutput("step1_done", 64'({BUSY, HALTED}), 64'd0);
    checkOutput("step1_count", 64'(GEN_COUNT), 64'd1);
    checkOutput("step1_adv", 64'(adv_count - base), 64'd1);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("step2_busy", 64'(BUSY), 64'd1);
    waitCycles(1);
    checkOutput("step2_halt", 64'({BUSY, HALTED, HALT_CAUSE}), 64'b0111);
    checkOutput("step2_count", 64'(GEN_COUNT), 64'd2);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("step3_ignored", 64'(BUSY), 64'd0);
    waitCycles(2);
    checkOutput("step3_adv", 64'(adv_count - base), 64'd2);

    $display("[TB] stop sequences");
    loadPattern(64'h0000_0000_1C00_0000, 16'd0);
    base = adv_count;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitCycles(3);
    checkOutput("start_stop_busy", 64'(BUSY), 64'd0);
    checkOutput("start_stop_adv", 64'(adv_count - base), 64'd0);

    loadPattern(64'h0000_001C_1008_0000, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waited = 0;
    while (GEN_COUNT != 16'd3 && waited < 50) begin
      @(posedge CLK); #1;
      waited++;
    end
    checkOutput("reached_gen3", 64'(GEN_COUNT), 64'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("stop_bound", 64'(GEN_COUNT >= 16'd3 && GEN_COUNT <= 16'd4), 64'd1);
    checkOutput("stop_idle", 64'({BUSY, HALTED, CLK_EN}), 64'd0);

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("run_clk_en", 64'({BUSY, CLK_EN}), 64'b11);
    #1 RESET_N = 1'b0;
    #1;
    checkOutput("async_clk_en", 64'(CLK_EN), 64'd0);
    checkOutput("async_outputs", 64'({LOAD_RUN, BUSY, GEN_COUNT}), 64'd0);
    #1 RESET_N = 1'b1;
    waitCycles(1);
    base = adv_count;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("post_reset_start", 64'(BUSY), 64'd0);
    checkOutput("post_reset_adv", 64'(adv_count - base), 64'd0);

    $display("[TB] random patterns");
    for (int i = 0; i < 20; i++) begin
      rpat = {$urandom, $urandom} & {$urandom, $urandom};
      plim = int'($urandom_range(12, 1));
      predict(rpat, plim, pgen, pcause, pfin);
      runCase(rpat, 16'(plim), 64'(pgen), 64'(pcause), pfin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
